// File: rtl/otter_muldiv_pkg.sv
// otter_muldiv_pkg
// Shared types and constants for the OTTER RV32M multiply/divide unit.
// Contents:
//   funct3_e    - M-extension operation encoding (FUNCT3 field)
//   state_e     - controller states (IDLE, CALC, FIX)
//   ITER        - datapath iterations per multiply/divide
//   DIV_ZERO_Q  - quotient returned for a zero divisor
//   INT_MIN     - most negative 32-bit value (signed overflow operand/result)
//   signed_a / signed_b / is_div - operand signedness and op class helpers
package otter_muldiv_pkg;

  localparam int unsigned ITER       = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  typedef enum logic [2:0] {
    F_MUL    = 3'b000,
    F_MULH   = 3'b001,
    F_MULHSU = 3'b010,
    F_MULHU  = 3'b011,
    F_DIV    = 3'b100,
    F_DIVU   = 3'b101,
    F_REM    = 3'b110,
    F_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // RS1 is unsigned only for the fully unsigned ops.
  function automatic logic signed_a(input funct3_e f);
    return !(f inside {F_MULHU, F_DIVU, F_REMU});
  endfunction

  // RS2 is additionally unsigned for MULHSU.
  function automatic logic signed_b(input funct3_e f);
    return !(f inside {F_MULHU, F_DIVU, F_REMU, F_MULHSU});
  endfunction

  function automatic logic is_div(input funct3_e f);
    return f inside {F_DIV, F_DIVU, F_REM, F_REMU};
  endfunction

endpackage

// File: rtl/otter_muldiv_fixup.sv
// otter_muldiv_fixup
// Combinational sign correction and result selection, evaluated while the
// controller sits in FIX. The iterative datapath only ever works on operand
// magnitudes; this block restores the signs and picks the architectural word.
// Ports:
//   op        in  funct3_e  latched operation
//   neg_a     in  1         RS1 was treated as signed and was negative
//   neg_b     in  1         RS2 was treated as signed and was negative
//   div_zero  in  1         divide with a zero divisor
//   div_ovf   in  1         signed divide INT_MIN / -1
//   prod      in  64        unsigned product of magnitudes
//   quot      in  32        unsigned quotient of magnitudes
//   rem       in  32        unsigned remainder of magnitudes
//   mag_a     in  32        magnitude of RS1 (dividend for the zero-divisor case)
//   result    out 32        final RV32M result
module otter_muldiv_fixup
  import otter_muldiv_pkg::*;
(
  input  funct3_e     op,
  input  logic        neg_a,
  input  logic        neg_b,
  input  logic        div_zero,
  input  logic        div_ovf,
  input  logic [63:0] prod,
  input  logic [31:0] quot,
  input  logic [31:0] rem,
  input  logic [31:0] mag_a,
  output logic [31:0] result
);

  logic        neg_res;
  logic [63:0] prod_s;
  logic [31:0] quot_s;
  logic [31:0] rem_s;
  logic [31:0] a_s;

  always_comb begin
    neg_res = neg_a ^ neg_b;
    prod_s  = neg_res ? -prod : prod;
    quot_s  = neg_res ? -quot : quot;
    // The remainder follows the dividend's sign.
    rem_s   = neg_a ? -rem : rem;
    // Re-signing the magnitude recovers the original RS1 bit pattern.
    a_s     = neg_a ? -mag_a : mag_a;

    result = '0;
    case (op)
      F_MUL:                     result = prod_s[31:0];
      F_MULH, F_MULHSU, F_MULHU: result = prod_s[63:32];
      F_DIV, F_DIVU: begin
        if (div_zero)     result = DIV_ZERO_Q;
        else if (div_ovf) result = INT_MIN;
        else              result = quot_s;
      end
      F_REM, F_REMU: begin
        if (div_zero)     result = a_s;
        else if (div_ovf) result = '0;
        else              result = rem_s;
      end
      default:           result = '0;
    endcase
  end

endmodule

// File: rtl/otter_muldiv.sv
// otter_muldiv
// Iterative RV32M multiply/divide unit. Radix-2 shift-add multiply and
// restoring divide on operand magnitudes, 32 iterations, followed by one
// FIX cycle that applies signs and registers the result.
// Ports:
//   CLK        in  1     system clock, rising edge
//   RST        in  1     synchronous active-high reset
//   START      in  1     operation request (sampled only while BUSY=0)
//   FUNCT3     in  3     M-extension operation select
//   OP_A       in  XLEN  RS1 value (multiplicand / dividend)
//   OP_B       in  XLEN  RS2 value (multiplier / divisor)
//   BUSY       out 1     unit occupied (state != IDLE)
//   DONE       out 1     one-cycle pulse, RESULT valid
//   RESULT     out XLEN  registered result, held until the next DONE
//   DBG_STATE  out 2     current controller state (state_e encoding)
//
// Handshake: a request is accepted on a rising edge where START=1 and
// BUSY=0; operands may change freely afterwards. BUSY then stays high until
// the edge that raises DONE. DONE is high for exactly one cycle with BUSY
// low, so a new START may be presented in the DONE cycle itself. START
// while BUSY=1 is dropped.
module otter_muldiv
  import otter_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OP_A,
  input  logic [XLEN-1:0] OP_B,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output logic [1:0]      DBG_STATE
);

  // Controller
  state_e state_q, state_d;
  logic   accept, calc_en, fix_en;

  // Latched operation and operand info
  funct3_e     op_q;
  logic        neg_a_q, neg_b_q;
  logic        div_zero_q, div_ovf_q;
  logic [31:0] mag_a_q, mag_b_q;
  logic [5:0]  cnt_q;

  // Datapath: acc holds {product hi, multiplier/product lo} for multiply,
  // and the dividend-shifting-out / quotient-shifting-in word in its low
  // half for divide. rem_q is the partial remainder.
  logic [63:0] acc_q;
  logic [31:0] rem_q;

  logic        done_q;
  logic [31:0] result_q;

  // Input decode at acceptance
  funct3_e     in_op;
  logic        in_neg_a, in_neg_b;
  logic [31:0] in_mag_a, in_mag_b;
  logic        in_div_zero, in_div_ovf, fast_path;

  // Iteration step
  logic [32:0] mul_sum;
  logic [32:0] div_part;
  logic        div_ge;
  logic [31:0] div_diff;

  logic [31:0] fix_result;

  always_comb begin
    in_op       = funct3_e'(FUNCT3);
    in_neg_a    = signed_a(in_op) & OP_A[31];
    in_neg_b    = signed_b(in_op) & OP_B[31];
    in_mag_a    = in_neg_a ? -OP_A : OP_A;
    in_mag_b    = in_neg_b ? -OP_B : OP_B;
    in_div_zero = is_div(in_op) && (OP_B == '0);
    in_div_ovf  = (in_op inside {F_DIV, F_REM}) && (OP_A == INT_MIN) && (OP_B == '1);
    // Both special cases have fixed answers, so skip the iterations.
    fast_path   = in_div_zero | in_div_ovf;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (START) state_d = fast_path ? S_FIX : S_CALC;
      S_CALC: if (cnt_q == 6'(ITER - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    BUSY    = (state_q != S_IDLE);
    accept  = (state_q == S_IDLE) && START;
    calc_en = (state_q == S_CALC);
    fix_en  = (state_q == S_FIX);
  end

  assign DBG_STATE = state_q;

  // ---------------- Iteration step ----------------
  always_comb begin
    // Multiply: conditionally add multiplicand into the upper half; the
    // 33rd bit keeps the carry that the following right shift brings down.
    mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? mag_a_q : 32'd0)};
    // Divide: shift the next dividend bit into a 33-bit partial remainder.
    div_part = {rem_q, acc_q[31]};
    div_ge   = (div_part >= {1'b0, mag_b_q});
    // When div_ge the difference is below the divisor, so 32 bits suffice.
    div_diff = div_part[31:0] - mag_b_q;
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q       <= F_MUL;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      mag_a_q    <= '0;
      mag_b_q    <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      done_q <= fix_en;

      if (accept) begin
        op_q       <= in_op;
        neg_a_q    <= in_neg_a;
        neg_b_q    <= in_neg_b;
        div_zero_q <= in_div_zero;
        div_ovf_q  <= in_div_ovf;
        mag_a_q    <= in_mag_a;
        mag_b_q    <= in_mag_b;
        cnt_q      <= '0;
        acc_q      <= {32'd0, (is_div(in_op) ? in_mag_a : in_mag_b)};
        rem_q      <= '0;
      end

      if (calc_en) begin
        cnt_q <= cnt_q + 6'd1;
        if (is_div(op_q)) begin
          rem_q <= div_ge ? div_diff : div_part[31:0];
          acc_q <= {acc_q[63:32], acc_q[30:0], div_ge};
        end else begin
          acc_q <= {mul_sum, acc_q[31:1]};
        end
      end

      if (fix_en) result_q <= fix_result;
    end
  end

  otter_muldiv_fixup u_fixup (
    .op       (op_q),
    .neg_a    (neg_a_q),
    .neg_b    (neg_b_q),
    .div_zero (div_zero_q),
    .div_ovf  (div_ovf_q),
    .prod     (acc_q),
    .quot     (acc_q[31:0]),
    .rem      (rem_q),
    .mag_a    (mag_a_q),
    .result   (fix_result)
  );

  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_otter_muldiv.sv
// tb_otter_muldiv
// Scoreboard bench for otter_muldiv: the driver pushes the reference result
// and expected latency when a START is accepted; the monitor pops and checks
// on every DONE.
module tb_otter_muldiv;
  import otter_muldiv_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  otter_muldiv #(.XLEN(32)) dut (
    .CLK       (clk),
    .RST       (rst),
    .START     (start),
    .FUNCT3    (funct3),
    .OP_A      (op_a),
    .OP_B      (op_b),
    .BUSY      (busy),
    .DONE      (done),
    .RESULT    (result),
    .DBG_STATE (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  int          acc_q[$];
  logic        prev_done = 1'b0;
  logic        issued_in_done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'b110: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Zero divisor or signed overflow bypasses the iterations.
  function automatic bit fast_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [31:0] e;
    int          l, a;
    if (done) begin
      check("done_single", {31'd0, prev_done}, 32'd0);
      check("busy_in_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got DONE with result %h, expected no DONE", result);
      end else begin
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        a = acc_q.pop_front();
        check("result", result, e);
        check("latency", 32'(cyc - a), 32'(l));
      end
    end
    prev_done = done;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_wait: busy got 1 expected 0 within 100 cycles");
      return;
    end
    issued_in_done = done;
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    @(negedge clk);
    // The accepting edge is now counted in cyc; scramble inputs afterwards.
    start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
    exp_q.push_back(ref_model(f, a, b));
    lat_q.push_back(fast_op(f, a, b) ? 1 : 33);
    acc_q.push_back(cyc);
  endtask

  // BUSY spans 32 CALC cycles plus the FIX cycle on the normal path.
  task automatic issue_count_busy(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input int exp_busy);
    int nb;
    int guard = 0;
    issue(f, a, b);
    nb = busy ? 1 : 0;
    while (!done && guard < 100) begin
      @(negedge clk);
      guard++;
      if (busy) nb++;
    end
    check("busy_cycles", 32'(nb), 32'(exp_busy));
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || busy) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    rst = 1'b0;

    // Directed vectors
    issue_count_busy(F_MUL, 32'd7, 32'd6, 33);
    issue(F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(F_MULH,   32'h8000_0000, 32'h8000_0000);
    issue(F_DIV,    32'hFFFF_FFF9, 32'd2);
    issue(F_REM,    32'hFFFF_FFF9, 32'd2);
    issue(F_DIVU,   32'd100, 32'd7);
    issue_count_busy(F_DIVU, 32'd100, 32'd0, 1);
    issue(F_REMU,   32'd100, 32'd0);
    issue(F_REM,    32'hFFFF_FF9C, 32'd0);
    issue(F_DIV,    32'h8000_0000, 32'hFFFF_FFFF);
    issue(F_REM,    32'h8000_0000, 32'hFFFF_FFFF);
    issue(F_DIVU,   32'h8000_0000, 32'hFFFF_FFFF);
    // Back-to-back: the second START lands in the first one's DONE cycle.
    issue(F_MUL,    32'd3, 32'd5);
    issue(F_MULHU,  32'h1234_5678, 32'h9ABC_DEF0);
    check("b2b_in_done", {31'd0, issued_in_done}, 32'd1);
    wait_idle();

    // START pulses while busy must be dropped (divisor 0 would be fast path).
    issue(F_DIVU, 32'd1000, 32'd3);
    repeat (4) begin
      @(negedge clk);
      start = 1'b1; funct3 = 3'($urandom); op_a = $urandom; op_b = 32'd0;
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
    repeat (40) @(negedge clk);

    // Reset during the 10th CALC cycle: no DONE, RESULT cleared.
    issue(F_MUL, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (9) @(negedge clk);
    check("mid_state_calc", {30'd0, dbg_state}, {30'd0, S_CALC});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    void'(acc_q.pop_back());
    repeat (40) @(negedge clk);

    // Reset wins over START in the same cycle.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; funct3 = F_MUL; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_over_start", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
    end
    wait_idle();
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
